// File: rtl/led_pulse_stretcher_if.sv
// Event/status bundle between game logic and the LED pulse stretcher.
// master: game logic (drives strobes, reads status).
// slave : the stretcher itself.
interface led_pulse_stretcher_if;
    logic       i_Event;
    logic       i_Clear;
    logic       o_Led;
    logic       o_Busy;
    logic [3:0] o_Pending;
    logic       o_Overflow;

    modport master (
        output i_Event,
        output i_Clear,
        input  o_Led,
        input  o_Busy,
        input  o_Pending,
        input  o_Overflow
    );

    modport slave (
        input  i_Event,
        input  i_Clear,
        output o_Led,
        output o_Busy,
        output o_Pending,
        output o_Overflow
    );
endinterface

// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher
// Expands single-cycle events into LED blinks of c_ON_CYCLES clocks followed
// by a forced dark gap of c_GAP_CYCLES clocks. One 24-bit down-counter is
// shared by the ON and GAP phases.
//
// Optional feature macro: LED_STRETCH_QUEUE_EN
//   defined   : events arriving during a blink are queued in a saturating
//               pending counter (up to c_PEND_MAX) and each one produces its
//               own blink; events beyond the cap set o_Overflow.
//   undefined : no queue, o_Pending reads 0, every event arriving during a
//               blink is dropped and sets o_Overflow.
//
// o_Led and o_Busy are registered from the current state, so they follow
// the state register by one clock: an event sampled in IDLE at edge N
// lights the LED from edge N+1 on.
module led_pulse_stretcher #(
    parameter int unsigned c_ON_CYCLES  = 2500000,
    parameter int unsigned c_GAP_CYCLES = 1250000,
    parameter int unsigned c_PEND_MAX   = 15
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_n,
    led_pulse_stretcher_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Counter reload values: the phase lasts load+1 clocks (counts down to 0).
    localparam logic [23:0] c_ON_LOAD  = 24'(c_ON_CYCLES - 1);
    localparam logic [23:0] c_GAP_LOAD = 24'(c_GAP_CYCLES - 1);
    localparam logic [3:0]  c_PEND_CAP = 4'(c_PEND_MAX);

    state_t      state_q;
    state_t      state_d;
    logic [23:0] cnt_q;
    logic [23:0] cnt_d;
    logic        led_q;
    logic        led_d;
    logic        busy_q;
    logic        busy_d;
    logic [3:0]  pend_q;
    logic [3:0]  pend_d;
    logic        ovf_q;
    logic        ovf_d;

    // An event that starts the next blink directly (IDLE entry or GAP end
    // with an empty queue) is consumed and never counted as pending.
    logic        ev_taken_s;
    // An event that arrives while a blink is in progress and is not consumed.
    logic        ev_extra_s;
    logic        ovf_set_s;
    logic        cnt_zero_s;

`ifdef LED_STRETCH_QUEUE_EN
    // A queued event was used to start a blink this cycle.
    logic        pend_dec_s;
`else
    logic        unused_pend_cap_s;
    assign unused_pend_cap_s = ^c_PEND_CAP;
`endif

    assign cnt_zero_s = (cnt_q == 24'd0);

    // Next-state and counter: phase sequencing IDLE -> ON -> GAP -> (ON|IDLE).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ev_taken_s = 1'b0;
`ifdef LED_STRETCH_QUEUE_EN
        pend_dec_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_Event) begin
                    state_d    = ST_ON;
                    cnt_d      = c_ON_LOAD;
                    ev_taken_s = 1'b1;
`ifdef LED_STRETCH_QUEUE_EN
                end else if (pend_q != 4'd0) begin
                    state_d    = ST_ON;
                    cnt_d      = c_ON_LOAD;
                    pend_dec_s = 1'b1;
`endif
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            ST_ON: begin
                if (cnt_zero_s) begin
                    state_d = ST_GAP;
                    cnt_d   = c_GAP_LOAD;
                end else begin
                    state_d = ST_ON;
                    cnt_d   = cnt_q - 24'd1;
                end
            end
            ST_GAP: begin
                if (cnt_zero_s) begin
`ifdef LED_STRETCH_QUEUE_EN
                    // Queued events take priority; a fresh event only
                    // starts the next blink directly when the queue is empty.
                    if (pend_q != 4'd0) begin
                        state_d    = ST_ON;
                        cnt_d      = c_ON_LOAD;
                        pend_dec_s = 1'b1;
                    end else if (bus.i_Event) begin
                        state_d    = ST_ON;
                        cnt_d      = c_ON_LOAD;
                        ev_taken_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 24'd0;
                    end
`else
                    state_d = ST_IDLE;
                    cnt_d   = 24'd0;
`endif
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = cnt_q - 24'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 24'd0;
            end
        endcase
    end

    // Pending queue and overflow detection for events arriving mid-blink.
    always_comb begin
        pend_d     = pend_q;
        ovf_set_s  = 1'b0;
        ev_extra_s = bus.i_Event && !ev_taken_s && (state_q != ST_IDLE);
`ifdef LED_STRETCH_QUEUE_EN
        if (ev_extra_s && pend_dec_s) begin
            // One queued event consumed, one new event queued: net zero.
            pend_d = pend_q;
        end else if (ev_extra_s) begin
            if (pend_q >= c_PEND_CAP) begin
                pend_d    = pend_q;
                ovf_set_s = 1'b1;
            end else begin
                pend_d = pend_q + 4'd1;
            end
        end else if (pend_dec_s) begin
            pend_d = pend_q - 4'd1;
        end else begin
            pend_d = pend_q;
        end
`else
        pend_d = 4'd0;
        if (ev_extra_s) begin
            ovf_set_s = 1'b1;
        end else begin
            ovf_set_s = 1'b0;
        end
`endif
    end

    // Sticky overflow: a new overflow beats a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (bus.i_Clear) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // LED and busy flags follow the current phase one clock later.
    always_comb begin
        led_d  = (state_q == ST_ON);
        busy_d = (state_q != ST_IDLE);
    end

    // State register, shared counter and output flops; async reset to idle.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 24'd0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.o_Led      = led_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_Pending  = pend_q;
    assign bus.o_Overflow = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Self-checking bench for led_pulse_stretcher (ON=4, GAP=2, PEND_MAX=3).
// A behavioural model predicts the outputs after each clock edge; the
// prediction is queued when the inputs are driven and popped and compared
// once the DUT has clocked. Works for both settings of LED_STRETCH_QUEUE_EN.
module tb_led_pulse_stretcher;

    localparam int ON_N   = 4;
    localparam int GAP_N  = 2;
    localparam int PMAX   = 3;
`ifdef LED_STRETCH_QUEUE_EN
    localparam bit QEN    = 1'b1;
`else
    localparam bit QEN    = 1'b0;
`endif

    typedef struct packed {
        logic       led;
        logic       busy;
        logic [3:0] pend;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   led_cnt;
    int   busy_cnt;
    int   cyc_no;

    // model state: phase 0=idle 1=on 2=gap, cycles left in phase
    int   m_state;
    int   m_left;
    int   m_pend;
    bit   m_ovf;
    exp_t sb[$];

    led_pulse_stretcher_if bus ();

    led_pulse_stretcher #(
        .c_ON_CYCLES  (ON_N),
        .c_GAP_CYCLES (GAP_N),
        .c_PEND_MAX   (PMAX)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_left  = 0;
        m_pend  = 0;
        m_ovf   = 1'b0;
        sb.delete();
    endtask

    // Predict outputs after the coming edge, given inputs sampled at it.
    task automatic model_step(input bit ev, input bit clr, output exp_t e);
        int  ns;
        int  nl;
        int  np;
        bit  took;
        bit  set;
        e.led  = (m_state == 1);
        e.busy = (m_state != 0);
        ns = m_state; nl = m_left; np = m_pend; took = 1'b0; set = 1'b0;
        if (m_state == 0) begin
            if (ev) begin ns = 1; nl = ON_N; took = 1'b1; end
            else if (QEN && m_pend > 0) begin ns = 1; nl = ON_N; np = m_pend - 1; end
        end else if (m_state == 1) begin
            if (m_left == 1) begin ns = 2; nl = GAP_N; end
            else nl = m_left - 1;
        end else begin
            if (m_left == 1) begin
                if (QEN && m_pend > 0) begin ns = 1; nl = ON_N; np = m_pend - 1; end
                else if (QEN && ev) begin ns = 1; nl = ON_N; took = 1'b1; end
                else ns = 0;
            end else nl = m_left - 1;
        end
        if (ev && !took && m_state != 0) begin
            if (!QEN) set = 1'b1;
            else if (np < m_pend) np = m_pend;
            else if (m_pend >= PMAX) set = 1'b1;
            else np = m_pend + 1;
        end
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_state = ns; m_left = nl; m_pend = np;
        e.pend = 4'(np);
        e.ovf  = m_ovf;
    endtask

    // One clock: drive, queue prediction, clock, pop and compare.
    task automatic cyc(input bit ev, input bit clr);
        exp_t e;
        exp_t g;
        bus.i_Event = ev;
        bus.i_Clear = clr;
        model_step(ev, clr, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
        g = sb.pop_front();
        chk($sformatf("led@%0d", cyc_no), {31'd0, bus.o_Led}, {31'd0, g.led});
        chk($sformatf("busy@%0d", cyc_no), {31'd0, bus.o_Busy}, {31'd0, g.busy});
        chk($sformatf("pend@%0d", cyc_no), {28'd0, bus.o_Pending}, {28'd0, g.pend});
        chk($sformatf("ovf@%0d", cyc_no), {31'd0, bus.o_Overflow}, {31'd0, g.ovf});
        if (bus.o_Led === 1'b1) led_cnt++;
        if (bus.o_Busy === 1'b1) busy_cnt++;
        bus.i_Event = 1'b0;
        bus.i_Clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_led"}, {31'd0, bus.o_Led}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.o_Busy}, 32'd0);
        chk({tag, "_pend"}, {28'd0, bus.o_Pending}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, bus.o_Overflow}, 32'd0);
    endtask

    initial begin
        total = 0; bad = 0; cyc_no = 0; led_cnt = 0; busy_cnt = 0;
        rst_n = 1'b0;
        bus.i_Event = 1'b0;
        bus.i_Clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Single pulse from IDLE.
        led_cnt = 0; busy_cnt = 0;
        cyc(1'b1, 1'b0);
        chk("single_led_latency0", {31'd0, bus.o_Led}, 32'd0);
        cyc(1'b0, 1'b0);
        chk("single_led_latency1", {31'd0, bus.o_Led}, 32'd1);
        idle(10);
        chk("single_led_len", led_cnt, ON_N);
        chk("single_busy_len", busy_cnt, ON_N + GAP_N);
        chk("single_pend_end", {28'd0, bus.o_Pending}, 32'd0);

        // Two extra pulses during blink cycles 1 and 2.
        led_cnt = 0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
`ifdef LED_STRETCH_QUEUE_EN
        chk("queue2_pend", {28'd0, bus.o_Pending}, 32'd2);
        chk("queue2_ovf", {31'd0, bus.o_Overflow}, 32'd0);
`else
        chk("drop_pend", {28'd0, bus.o_Pending}, 32'd0);
        chk("drop_ovf", {31'd0, bus.o_Overflow}, 32'd1);
`endif
        idle(24);
        chk("queue2_led_total", led_cnt, QEN ? 3 * ON_N : ON_N);
        cyc(1'b0, 1'b1);
        chk("clear_ovf_a", {31'd0, bus.o_Overflow}, 32'd0);

        // Event held for 10 clocks: saturation and overflow, then clear.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        chk("held_ovf", {31'd0, bus.o_Overflow}, 32'd1);
        chk("held_pend", {28'd0, bus.o_Pending}, QEN ? 32'(PMAX) : 32'd0);
        cyc(1'b0, 1'b1);
        chk("held_clear_ovf", {31'd0, bus.o_Overflow}, 32'd0);
        chk("held_clear_pend", {28'd0, bus.o_Pending}, QEN ? 32'(PMAX) : 32'd0);
        idle(30);
        cyc(1'b0, 1'b1);

        // Event on the final GAP clock with one event already queued.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        idle(4);
        cyc(1'b1, 1'b0);
        chk("gapend_pend", {28'd0, bus.o_Pending}, QEN ? 32'd1 : 32'd0);
        idle(20);
        cyc(1'b0, 1'b1);

        // Simultaneous overflow and clear: overflow wins.
        cyc(1'b1, 1'b0);
        if (QEN) for (int i = 0; i < PMAX; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("ovf_beats_clear", {31'd0, bus.o_Overflow}, 32'd1);
        idle(30);
        cyc(1'b0, 1'b1);

        // Asynchronous reset on ON clock 2, mid-blink, with state pending.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk_zero("async_rst_hold");
        rst_n = 1'b1;
        led_cnt = 0; busy_cnt = 0;
        idle(12);
        chk("post_rst_no_blink", led_cnt, 0);
        chk("post_rst_no_busy", busy_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
